// File: rtl/alu_seq_machine.sv
// alu_seq_machine: multi-cycle unsigned ALU with valid/ready handshakes.
//   OP 00 add, 01 multiply (shift-add), 10 divide (restoring), 11 subtract.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (A, B, OP captured on accept)
//   out_valid/out_ready result handshake (Out, Extra, dz held until consumed)
//   Out                 primary result (sum, difference, low product, quotient)
//   Extra               carry, borrow, high product or remainder
//   dz                  divide-by-zero flag
module alu_seq_machine #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] Extra,
    output logic             dz
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [1:0]           op_q, op_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     out_q, out_d, extra_q, extra_d;
    logic                 dz_q, dz_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [WIDTH:0]       add_sum, sub_diff, mul_sum, div_trial, div_diff;
    logic [2*WIDTH-1:0]   mul_next;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem_next, div_q_next;

    // Next-state, datapath step and registered outputs
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        out_d       = out_q;
        extra_d     = extra_q;
        dz_d        = dz_q;

        add_sum  = {1'b0, A} + {1'b0, B};
        sub_diff = {1'b0, A} - {1'b0, B};

        // Multiply: acc = {high partial, remaining multiplier bits}; add then shift right
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: acc low half shifts dividend out MSB-first and quotient bits in
        div_trial    = {rem_q, acc_q[WIDTH-1]};
        div_diff     = div_trial - {1'b0, b_q};
        div_ge       = ~div_diff[WIDTH];
        div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
        div_q_next   = {acc_q[WIDTH-2:0], div_ge};

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d  = A;
                    b_d  = B;
                    op_d = OP;
                    if (OP == OP_MUL || OP == OP_DIV) begin
                        acc_d   = (OP == OP_MUL) ? {{WIDTH{1'b0}}, B} : {{WIDTH{1'b0}}, A};
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_CALC;
                    end else begin
                        out_d   = (OP == OP_SUB) ? sub_diff[WIDTH-1:0] : add_sum[WIDTH-1:0];
                        extra_d = (OP == OP_SUB) ? WIDTH'(sub_diff[WIDTH]) : WIDTH'(add_sum[WIDTH]);
                        dz_d    = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_next;
                end else begin
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], div_q_next};
                    rem_d = div_rem_next;
                end
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    if (op_q == OP_MUL) begin
                        out_d   = mul_next[WIDTH-1:0];
                        extra_d = mul_next[2*WIDTH-1:WIDTH];
                        dz_d    = 1'b0;
                    end else if (b_q == '0) begin
                        out_d   = '1;
                        extra_d = a_q;
                        dz_d    = 1'b1;
                    end else begin
                        out_d   = div_q_next;
                        extra_d = div_rem_next;
                        dz_d    = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            out_q       <= '0;
            extra_q     <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            out_q       <= out_d;
            extra_q     <= extra_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Out       = out_q;
    assign Extra     = extra_q;
    assign dz        = dz_q;

endmodule
